// File: rtl/lane_traffic_gen_if.sv
// Lane engine bus: frame strobe, run controls, pixel scan position, player
// position in; per-pixel car info, collision flag and pass count out.
// The master drives the engine and the slave is the engine itself.
interface lane_traffic_gen_if;
  logic        frame_clk;
  logic        enable;
  logic [31:0] seed;
  logic [9:0]  step_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic        collision_clr;
  logic        is_car;
  logic [9:0]  pixel_x_in_car;
  logic [9:0]  pixel_y_in_car;
  logic        collision;
  logic [15:0] cars_passed;

  modport master (
    output frame_clk, enable, seed, step_y, DrawX, DrawY, player_x, player_y, collision_clr,
    input  is_car, pixel_x_in_car, pixel_y_in_car, collision, cars_passed
  );

  modport slave (
    input  frame_clk, enable, seed, step_y, DrawX, DrawY, player_x, player_y, collision_clr,
    output is_car, pixel_x_in_car, pixel_y_in_car, collision, cars_passed
  );
endinterface

// File: rtl/lane_traffic_gen.sv
// Obstacle-lane engine: NUM_CARS car slots in one road lane, LFSR-driven
// spawning, per-frame motion, per-pixel hit/offset, sticky player collision
// and a saturating passed-car count.
// Optional: define LANE_SPEEDUP_EN to add one pixel/frame of speed for every
// 16 retired cars, capped at twice step_y.

// One car slot: IDLE/ACTIVE state, position, pixel hit and player overlap.
module lane_car_slot #(
  parameter logic [9:0] CAR_W = 10'd32,
  parameter logic [9:0] CAR_H = 10'd64,
  parameter logic [9:0] Y_MAX = 10'd479
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] step,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       active,
  output logic       retire,
  output logic       hit,
  output logic       overlap,
  output logic [9:0] off_x,
  output logic [9:0] off_y
);
  logic [9:0]  x, y, nxt_x, nxt_y;
  logic        nxt_active;
  logic [10:0] sum;
  logic [10:0] hx_l, hx_r, hy_t, hy_b;
  logic [10:0] nx_l, nx_r, ny_t, ny_b, px_l, px_r, py_t, py_b;

  assign sum    = {1'b0, y} + {1'b0, step};
  assign retire = adv && active && (sum >= {1'b0, Y_MAX});

  // next-state: move or retire when active, load on a spawn grant when idle
  always_comb begin
    nxt_active = active;
    nxt_x      = x;
    nxt_y      = y;
    if (adv) begin
      if (active) begin
        if (retire) begin
          nxt_active = 1'b0;
          nxt_y      = '0;
        end else begin
          nxt_y = sum[9:0];
        end
      end else if (spawn) begin
        nxt_active = 1'b1;
        nxt_x      = spawn_x;
        nxt_y      = '0;
      end
    end
  end

  // slot state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      active <= nxt_active;
      x      <= nxt_x;
      y      <= nxt_y;
    end
  end

  // 11-bit bounds so x+CAR_W-1 never wraps near the right screen edge
  assign hx_l = {1'b0, x};
  assign hx_r = hx_l + {1'b0, CAR_W} - 11'd1;
  assign hy_t = {1'b0, y};
  assign hy_b = hy_t + {1'b0, CAR_H} - 11'd1;

  assign hit = active &&
               ({1'b0, draw_x} >= hx_l) && ({1'b0, draw_x} <= hx_r) &&
               ({1'b0, draw_y} >= hy_t) && ({1'b0, draw_y} <= hy_b);
  assign off_x = draw_x - x;
  assign off_y = draw_y - y;

  // overlap is judged on the post-move position so the frame's move counts
  assign nx_l = {1'b0, nxt_x};
  assign nx_r = nx_l + {1'b0, CAR_W} - 11'd1;
  assign ny_t = {1'b0, nxt_y};
  assign ny_b = ny_t + {1'b0, CAR_H} - 11'd1;
  assign px_l = {1'b0, player_x};
  assign px_r = px_l + {1'b0, CAR_W} - 11'd1;
  assign py_t = {1'b0, player_y};
  assign py_b = py_t + {1'b0, CAR_H} - 11'd1;

  assign overlap = nxt_active && (nx_l <= px_r) && (px_l <= nx_r) &&
                   (ny_t <= py_b) && (py_t <= ny_b);
endmodule

module lane_traffic_gen #(
  parameter int unsigned NUM_CARS       = 3,
  parameter logic [9:0]  CAR_W          = 10'd32,
  parameter logic [9:0]  CAR_H          = 10'd64,
  parameter logic [9:0]  X_BASE         = 10'd160,
  parameter logic [9:0]  SUBLANE_OFFSET = 10'd63,
  parameter logic [9:0]  Y_MAX          = 10'd479,
  parameter logic [7:0]  MIN_GAP        = 8'd40,
  parameter logic [2:0]  SPAWN_THRESH   = 3'd3
) (
  input logic               Clk,
  input logic               Reset,
  lane_traffic_gen_if.slave bus
);
  logic [2:0]  fsync;
  logic        frame_tick, adv;
  logic [15:0] lfsr, lfsr_nxt, seed_init;
  logic [7:0]  gap_cnt;
  logic [15:0] passed_q, passed_nxt;
  logic [16:0] passed_sum;
  logic [3:0]  n_ret;
  logic        grant, any_idle, found;
  logic [9:0]  spawn_x, eff_step;
  logic        unused_seed_hi;

  logic [NUM_CARS-1:0]       active, retire, hit, overlap, spawn_vec;
  logic [NUM_CARS-1:0][9:0]  off_x, off_y;

  logic       is_car_c;
  logic [9:0] pix_x_c, pix_y_c;
  logic       collision_q;

  assign unused_seed_hi = ^bus.seed[31:16];

  // frame strobe: 2-FF synchroniser, edge-detect stage, registered 1-Clk tick
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync      <= '0;
      frame_tick <= 1'b0;
    end else begin
      fsync      <= {fsync[1:0], bus.frame_clk};
      frame_tick <= fsync[1] & ~fsync[2];
    end
  end

  assign adv = frame_tick & bus.enable;

  assign seed_init = (bus.seed[15:0] == 16'h0) ? 16'hACE1 : bus.seed[15:0];
  assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // grant only looks at slots idle at frame start, so a retiring slot waits
  assign any_idle = ~&active;
  assign grant    = adv && (gap_cnt >= MIN_GAP) && (lfsr[2:0] < SPAWN_THRESH) && any_idle;
  assign spawn_x  = X_BASE + (lfsr[3] ? SUBLANE_OFFSET : 10'd0);

  // one-hot grant to the lowest-index idle slot
  always_comb begin
    spawn_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (!active[i] && !found) begin
        spawn_vec[i] = grant;
        found        = 1'b1;
      end
    end
  end

  // several slots may retire in one frame; each one counts
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < NUM_CARS; i++) n_ret = n_ret + {3'b000, retire[i]};
  end

  assign passed_sum = {1'b0, passed_q} + {13'b0, n_ret};
  assign passed_nxt = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

`ifdef LANE_SPEEDUP_EN
  logic [9:0]  speed_add;
  logic [10:0] eff_sum, eff_cap, eff_min;

  assign eff_sum  = {1'b0, bus.step_y} + {1'b0, speed_add};
  assign eff_cap  = {bus.step_y, 1'b0};
  assign eff_min  = (eff_sum > eff_cap) ? eff_cap : eff_sum;
  assign eff_step = eff_min[10] ? 10'h3FF : eff_min[9:0];

  // bump the speed each time the pass count enters a new block of 16
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      speed_add <= '0;
    else if (adv && (passed_nxt[15:4] != passed_q[15:4]) &&
             (eff_sum < eff_cap) && (speed_add != 10'h3FF))
      speed_add <= speed_add + 10'd1;
  end
`else
  assign eff_step = bus.step_y;
`endif

  // per-frame lane state: LFSR, spawn gap counter, passed-car count
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr     <= seed_init;
      gap_cnt  <= '0;
      passed_q <= '0;
    end else if (adv) begin
      lfsr     <= lfsr_nxt;
      gap_cnt  <= grant ? 8'd0 : ((gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1);
      passed_q <= passed_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CARS; g++) begin : g_slot
      lane_car_slot #(.CAR_W(CAR_W), .CAR_H(CAR_H), .Y_MAX(Y_MAX)) u_slot (
        .clk     (Clk),
        .rst_n   (Reset),
        .adv     (adv),
        .spawn   (spawn_vec[g]),
        .spawn_x (spawn_x),
        .step    (eff_step),
        .draw_x  (bus.DrawX),
        .draw_y  (bus.DrawY),
        .player_x(bus.player_x),
        .player_y(bus.player_y),
        .active  (active[g]),
        .retire  (retire[g]),
        .hit     (hit[g]),
        .overlap (overlap[g]),
        .off_x   (off_x[g]),
        .off_y   (off_y[g])
      );
    end
  endgenerate

  // pixel mux: later (higher-index) hits override earlier ones
  always_comb begin
    is_car_c = 1'b0;
    pix_x_c  = '0;
    pix_y_c  = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (hit[i]) begin
        is_car_c = 1'b1;
        pix_x_c  = off_x[i];
        pix_y_c  = off_y[i];
      end
    end
  end

  // sticky collision; a same-cycle set beats the clear
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      collision_q <= 1'b0;
    else if (adv && |overlap)
      collision_q <= 1'b1;
    else if (bus.collision_clr)
      collision_q <= 1'b0;
  end

  assign bus.is_car         = is_car_c;
  assign bus.pixel_x_in_car = pix_x_c;
  assign bus.pixel_y_in_car = pix_y_c;
  assign bus.collision      = collision_q;
  assign bus.cars_passed    = passed_q;
endmodule

// File: tb/tb_lane_traffic_gen.sv
// Directed bench for lane_traffic_gen: reset state, LFSR stepping, spawn gap,
// motion, retirement, overlap priority, sticky collision, freeze and async reset.
// Sub-lane offset is narrowed to 16 so cars in either sub-lane share columns.
module tb_lane_traffic_gen;
  localparam logic [9:0] XB = 10'd160;
  localparam logic [9:0] SO = 10'd16;
  localparam logic [9:0] DX = 10'd180;  // column covered by both sub-lanes

  logic Clk = 1'b0;
  logic Reset;
  lane_traffic_gen_if bus();

  lane_traffic_gen #(.NUM_CARS(3), .SUBLANE_OFFSET(SO), .SPAWN_THRESH(3'd7)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // lane model: used for spawn timing and spawned x only
  logic [15:0] m_lfsr;
  logic [7:0]  m_gap;
  bit   [2:0]  m_act;
  int          m_y [3];
  logic [9:0]  m_x [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset(input logic [31:0] s);
    m_lfsr = (s[15:0] == 16'h0) ? 16'hACE1 : s[15:0];
    m_gap  = 8'd0;
    m_act  = 3'b000;
    for (int i = 0; i < 3; i++) begin m_y[i] = 0; m_x[i] = 10'd0; end
  endtask

  task automatic m_tick();
    bit [2:0] idle0;
    bit       grant, done;
    if (!bus.enable) return;
    idle0 = ~m_act;
    grant = (m_gap >= 8'd40) && (m_lfsr[2:0] < 3'd7) && (idle0 != 3'b000);
    for (int i = 0; i < 3; i++) begin
      if (m_act[i]) begin
        if (m_y[i] + int'(bus.step_y) >= 479) begin m_act[i] = 1'b0; m_y[i] = 0; end
        else m_y[i] = m_y[i] + int'(bus.step_y);
      end
    end
    if (grant) begin
      done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (idle0[i] && !done) begin
          m_act[i] = 1'b1; m_y[i] = 0; m_x[i] = XB + (m_lfsr[3] ? SO : 10'd0); done = 1'b1;
        end
      end
      m_gap = 8'd0;
    end else if (m_gap != 8'hFF) begin
      m_gap = m_gap + 8'd1;
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  // one frame strobe; optional collision_clr exactly on the tick-sampling edge
  task automatic frame(input bit clr_at_tick);
    @(posedge Clk); #1 bus.frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    @(posedge Clk); #1 if (clr_at_tick) bus.collision_clr = 1'b1;
    @(posedge Clk); #1 bus.collision_clr = 1'b0;
    m_tick();
    bus.frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic wait_spawn(input int slot, input string tag);
    int n;
    n = 0;
    while (!m_act[slot] && n < 300) begin frame(1'b0); n++; end
    if (!m_act[slot]) begin
      checks++; errors++;
      $error("FAIL %s no spawn within 300 frames", tag);
    end
  endtask

  task automatic do_reset(input logic [31:0] s);
    bus.seed = s;
    bus.frame_clk = 1'b0;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    m_reset(s);
  endtask

  task automatic clr_pulse();
    @(posedge Clk); #1 bus.collision_clr = 1'b1;
    @(posedge Clk); #1 bus.collision_clr = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                     input logic e_hit, input logic [9:0] ex, input logic [9:0] ey);
    bus.DrawX = dx; bus.DrawY = dy; #1;
    chk({tag, ".hit"}, {31'b0, bus.is_car}, {31'b0, e_hit});
    chk({tag, ".px"}, {22'b0, bus.pixel_x_in_car}, {22'b0, ex});
    chk({tag, ".py"}, {22'b0, bus.pixel_y_in_car}, {22'b0, ey});
  endtask

  function automatic logic [9:0] offx(input int k);
    return DX - m_x[k];
  endfunction

  initial begin
    logic [9:0] x0;
    Reset = 1'b0;
    bus.frame_clk = 1'b0; bus.enable = 1'b1; bus.seed = 32'h0; bus.step_y = 10'd0;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.player_x = 10'd600; bus.player_y = 10'd400;
    bus.collision_clr = 1'b0;

    // reset with seed 0: fallback seed, everything clear
    do_reset(32'h0);
    chk("rst.lfsr", {16'b0, dut.lfsr}, 32'h0000ACE1);
    chk("rst.coll", {31'b0, bus.collision}, 32'd0);
    chk("rst.passed", {16'b0, bus.cars_passed}, 32'd0);
    pix("rst.pix", DX, 10'd0, 1'b0, 10'd0, 10'd0);
    frame(1'b0);
    chk("lfsr.step1", {16'b0, dut.lfsr}, 32'h0000E270);
    frames(39);
    pix("gap40.nospawn", DX, 10'd0, 1'b0, 10'd0, 10'd0);
    chk("lfsr.step40", {16'b0, dut.lfsr}, {16'b0, m_lfsr});

    // seed 1: no spawn before the gap, then spawn into slot 0 at y=0
    do_reset(32'h1);
    frames(40);
    pix("s1.nospawn", DX, 10'd0, 1'b0, 10'd0, 10'd0);
    wait_spawn(0, "s1.spawn");
    pix("s1.y0", DX, 10'd0, 1'b1, offx(0), 10'd0);
    bus.step_y = 10'd8;
    frame(1'b0);
    pix("s1.y8", DX, 10'd13, 1'b1, offx(0), 10'd5);
    pix("s1.above", DX, 10'd7, 1'b0, 10'd0, 10'd0);
    pix("s1.bottom", DX, 10'd71, 1'b1, offx(0), 10'd63);
    pix("s1.below", DX, 10'd72, 1'b0, 10'd0, 10'd0);
    x0 = m_x[0];
    pix("s1.right", x0 + 10'd31, 10'd13, 1'b1, 10'd31, 10'd5);
    pix("s1.pastright", x0 + 10'd32, 10'd13, 1'b0, 10'd0, 10'd0);
    pix("s1.left", x0 - 10'd1, 10'd13, 1'b0, 10'd0, 10'd0);

    // move to y=472, then 472+8=480 retires
    bus.step_y = 10'd464;
    frame(1'b0);
    pix("ret.y472", DX, 10'd472, 1'b1, offx(0), 10'd0);
    bus.step_y = 10'd8;
    frame(1'b0);
    chk("ret.passed", {16'b0, bus.cars_passed}, 32'd1);
    pix("ret.gone", DX, 10'd472, 1'b0, 10'd0, 10'd0);
    pix("ret.notop", DX, 10'd0, 1'b0, 10'd0, 10'd0);

    // stack: s0 reused, s0->460, s1, ->465/5, s2, retire s0, reuse s0
    bus.step_y = 10'd0;
    wait_spawn(0, "ov.s0");
    bus.step_y = 10'd460; frame(1'b0);
    bus.step_y = 10'd0;
    wait_spawn(1, "ov.s1");
    bus.step_y = 10'd5; frame(1'b0);
    bus.step_y = 10'd0;
    wait_spawn(2, "ov.s2");
    bus.step_y = 10'd14; frame(1'b0);
    chk("ov.passed", {16'b0, bus.cars_passed}, 32'd2);
    bus.step_y = 10'd0;
    wait_spawn(0, "ov.s0again");
    // now s0 y=0, s1 y=19, s2 y=14
    pix("ov.s0s2", DX, 10'd16, 1'b1, offx(2), 10'd2);
    pix("ov.s1s2", DX, 10'd70, 1'b1, offx(2), 10'd56);
    pix("ov.s1only", DX, 10'd80, 1'b1, offx(1), 10'd61);
    pix("ov.s0only", DX, 10'd5, 1'b1, offx(0), 10'd5);

    // collision: set, sticky, clear, edge touch, set beats clear
    bus.player_x = m_x[2]; bus.player_y = 10'd74; frame(1'b0);
    chk("col.set", {31'b0, bus.collision}, 32'd1);
    bus.player_x = 10'd600; bus.player_y = 10'd400; frame(1'b0);
    chk("col.sticky", {31'b0, bus.collision}, 32'd1);
    clr_pulse();
    chk("col.clr", {31'b0, bus.collision}, 32'd0);
    bus.player_x = m_x[1]; bus.player_y = 10'd83; frame(1'b0);
    chk("col.gap1", {31'b0, bus.collision}, 32'd0);
    bus.player_y = 10'd82; frame(1'b0);
    chk("col.touch", {31'b0, bus.collision}, 32'd1);
    clr_pulse();
    bus.player_x = m_x[2]; bus.player_y = 10'd74; frame(1'b1);
    chk("col.setwins", {31'b0, bus.collision}, 32'd1);
    bus.player_x = 10'd600; bus.player_y = 10'd400;
    clr_pulse();
    chk("col.clr2", {31'b0, bus.collision}, 32'd0);

    // freeze: 10 ticks with enable low change nothing
    bus.step_y = 10'd8; bus.enable = 1'b0;
    frames(10);
    chk("frz.lfsr", {16'b0, dut.lfsr}, {16'b0, m_lfsr});
    chk("frz.passed", {16'b0, bus.cars_passed}, 32'd2);
    pix("frz.pos", DX, 10'd5, 1'b1, offx(0), 10'd5);
    bus.enable = 1'b1;
    bus.player_x = m_x[0]; bus.player_y = 10'd8;
    frame(1'b0);
    chk("run.lfsr", {16'b0, dut.lfsr}, {16'b0, m_lfsr});
    pix("run.pos", DX, 10'd10, 1'b1, offx(0), 10'd2);
    chk("run.coll", {31'b0, bus.collision}, 32'd1);

    // async reset mid-frame clears at once and drops the pending tick
    bus.player_x = 10'd600; bus.player_y = 10'd400;
    @(posedge Clk); #1 bus.frame_clk = 1'b1;
    @(posedge Clk); @(posedge Clk); #3 Reset = 1'b0;
    pix("ar.pix", DX, 10'd10, 1'b0, 10'd0, 10'd0);
    chk("ar.passed", {16'b0, bus.cars_passed}, 32'd0);
    chk("ar.coll", {31'b0, bus.collision}, 32'd0);
    chk("ar.lfsr", {16'b0, dut.lfsr}, 32'h00000001);
    bus.frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;
    m_reset(32'h1);
    repeat (6) @(posedge Clk);
    #1;
    chk("ar.notick", {16'b0, dut.lfsr}, 32'h00000001);
    frame(1'b0);
    chk("ar.step", {16'b0, dut.lfsr}, 32'h0000B400);
    pix("ar.empty", DX, 10'd0, 1'b0, 10'd0, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lane_traffic_gen.md
Name: lane_traffic_gen

Overview:
Parametrised obstacle-lane engine for the two-cars game. It manages NUM_CARS yellow-car slots in one road lane. Spawns are randomised by an internal LFSR, cars are moved once per frame, and the block reports the per-pixel car hit, in-car pixel offset, collision with the player car and a passed-car count. One instance per lane sits between the VGA frame timing and the colour mapper; each instance takes a distinct seed.

Parameters:
NUM_CARS, 3, number of car slots (1..8)
CAR_W, 10'd32, car sprite width in pixels
CAR_H, 10'd64, car sprite height in pixels
X_BASE, 10'd160, left x of sub-lane 0
SUBLANE_OFFSET, 10'd63, x offset of sub-lane 1 from X_BASE
Y_MAX, 10'd479, y at or beyond which a car retires
MIN_GAP, 8'd40, minimum frames between spawns
SPAWN_THRESH, 3'd3, spawn when lfsr[2:0] < SPAWN_THRESH

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  vsync-rate frame strobe, asynchronous to Clk
enable  in  1  1 = run, 0 = freeze all motion, spawning and LFSR
seed  in  32  LFSR seed; bits [15:0] are used
step_y  in  10  pixels moved per frame
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
player_x  in  10  player car top-left x
player_y  in  10  player car top-left y
collision_clr  in  1  clears sticky collision
is_car  out  1  current pixel is inside an active car
pixel_x_in_car  out  10  DrawX minus the hit car's x
pixel_y_in_car  out  10  DrawY minus the hit car's y
collision  out  1  sticky player-car overlap flag
cars_passed  out  16  count of retired cars

Behaviour:
- Reset: asynchronous assert, synchronous release. Every slot goes to IDLE with x = 0 and y = 0. LFSR loads seed[15:0], or 16'hACE1 if that value is 0. gap_cnt = 0, collision = 0, cars_passed = 0.
- frame_clk passes through a 2-FF synchroniser and a rising-edge detector. frame_tick is a 1-Clk pulse that occurs 3 Clk after the edge. All per-frame actions below occur only on frame_tick with enable = 1.
- LFSR: 16-bit Galois, mask 16'hB400, shift right, advances one step per frame_tick.
- gap_cnt: 8-bit, increments per frame, saturates at 255.
- Per-slot FSM:
  - IDLE -> ACTIVE on a spawn grant.
  - ACTIVE: y <= y + step_y, computed in 11 bits. When the 11-bit sum is >= Y_MAX, the slot goes to IDLE, y is set to 0, and cars_passed increments (saturating at 16'hFFFF).
- Spawn grant: requires all of the following in the same frame:
  - gap_cnt >= MIN_GAP
  - lfsr[2:0] < SPAWN_THRESH
  - at least one IDLE slot exists
- On a grant:
  - The lowest-index IDLE slot is loaded with y = 0 and x = X_BASE + (lfsr[3] ? SUBLANE_OFFSET : 0).
  - gap_cnt is set to 0.
  - At most one spawn occurs per frame.
  - A slot retiring in this frame is not eligible to respawn in the same frame.
- All slots IDLE with no grant: only gap_cnt advances.
- Pixel output (combinational from registered positions):
  - A hit requires an ACTIVE slot with x <= DrawX <= x+CAR_W-1 and y <= DrawY <= y+CAR_H-1.
  - When several slots hit, the highest index wins.
  - With no hit: is_car = 0 and the offsets output 0.
- Collision:
  - Evaluated on frame_tick after the move.
  - Sets if any ACTIVE slot's rectangle overlaps the CAR_W x CAR_H player rectangle at (player_x, player_y), including edge-touching pixels.
  - Remains set until collision_clr = 1 is sampled on a Clk edge.
  - If clr and set occur in the same cycle, set wins.
  - collision_clr is independent of enable.
- enable = 0: positions, LFSR, gap_cnt and cars_passed all hold. Pixel outputs stay live.
- Reset asserted mid-frame: all state returns immediately to reset values. A pending frame_tick is discarded.

Optional Feature:
LANE_SPEEDUP_EN
- Defined: an internal eff_step starts at step_y. It increments by 1 each time cars_passed crosses a multiple of 16, saturating at 2*step_y. Reset restores eff_step to step_y. The slot FSM uses eff_step.
- Undefined: the slot FSM uses step_y directly and no speedup logic exists.

Test Plan:
- Reset with seed = 0 -> LFSR = 16'hACE1; all outputs 0; no spawn in the first 40 frames (MIN_GAP).
- seed = 32'h1, SPAWN_THRESH forced 7, step_y = 8 -> the first spawn occurs at frame 40 in slot 0 with y = 0. At the next frame, y = 8. pixel_x_in_car = DrawX - x at DrawY = y + 5.
- Slot at y = 472, step_y = 8 -> the slot retires (480 >= 479); cars_passed goes 0 -> 1; the slot is IDLE and reusable on a later grant.
- Two overlapping cars, slots 0 and 2, covering the same DrawX/DrawY -> offsets are taken from slot 2.
- Player at (x, y + 60) of an active car -> collision = 1 after that frame_tick. It stays 1 with the player moved away. collision_clr for 1 Clk -> 0. clr concurrent with a new overlap -> stays 1.
- enable = 0 across 10 frame_ticks -> positions, LFSR and cars_passed unchanged. Async Reset pulse mid-motion -> all slots IDLE within the same cycle.
